// File: rtl/ftdi_rx_frame_pkg.sv
// Shared definitions for the FT60x receive frame parser: header field
// positions, the default sync pattern, the parser state encoding and the
// running checksum update.
package ftdi_rx_frame_pkg;

  // Default sync pattern expected in the upper half of a header word
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

  // Header word layout: {SYNC[15:0], LEN[15:0]}
  localparam int unsigned HDR_SYNC_MSB = 32'd31;
  localparam int unsigned HDR_SYNC_LSB = 32'd16;
  localparam int unsigned HDR_LEN_MSB  = 32'd15;
  localparam int unsigned HDR_LEN_LSB  = 32'd0;

  // Parser states
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_e;

  // Frame checksum is the XOR of all payload words
  function automatic logic [31:0] csum_update(input logic [31:0] acc,
                                              input logic [31:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/ftdi_sat_counter.sv
// Saturating event counter used for the parser statistics. Holds at
// all-ones once reached so a stuck error source never wraps back to a
// small, innocent-looking value.
module ftdi_sat_counter #(
  parameter int unsigned CNT_W = 32'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count enabled events, pinning at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc_en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1'b1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ftdi_rx_frame_parser.sv
// FT60x receive frame parser. Hunts for a {SYNC, LEN} header in the raw
// USB word stream, forwards LEN payload words as one AXI4-Stream packet
// (tlast on the final word, tuser = error), checks the trailing XOR
// checksum and aborts frames whose input stalls for TIMEOUT cycles.
// Payload is staged through a one-word hold register so the last word can
// be tagged with tlast/tuser once the checksum (or timeout) is known.
module ftdi_rx_frame_parser
  import ftdi_rx_frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned MAX_LEN   = 32'd1024,
  parameter int unsigned TIMEOUT   = 32'd65535,
  parameter int unsigned CNT_W     = 32'd16
) (
  input  logic             rx_clk,
  input  logic             rx_rstn,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             busy,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] csum_err_cnt,
  output logic [CNT_W-1:0] tout_cnt
);

  localparam int unsigned    IDLE_W      = $clog2(TIMEOUT + 32'd1);
  localparam logic [15:0]    MAX_LEN_C   = 16'(MAX_LEN);
  localparam logic [IDLE_W-1:0] TOUT_LAST_C = IDLE_W'(TIMEOUT - 32'd1);

  // Parser state
  rx_state_e         state_r;
  logic [15:0]       len_r;
  logic [15:0]       wcnt_r;
  logic [31:0]       csum_r;
  logic [31:0]       hold_r;
  logic              hold_vld_r;
  logic [IDLE_W-1:0] idle_r;

  // Registered output stage
  logic              m_valid_r;
  logic [31:0]       m_data_r;
  logic              m_last_r;
  logic              m_user_r;

  // Decode
  logic              out_free_s;
  logic              s_ready_s;
  logic              accept_s;
  logic [15:0]       hdr_sync_s;
  logic [15:0]       hdr_len_s;
  logic              sync_match_s;
  logic              len_ok_s;
  logic              tout_fire_s;
  logic              push_s;
  logic              push_last_s;
  logic              push_user_s;
  logic              ok_inc_s;
  logic              sync_inc_s;
  logic              len_inc_s;
  logic              csum_inc_s;
  logic              tout_inc_s;

  // USB transfer boundaries carry no framing meaning
  logic              unused_tlast_s;
  assign unused_tlast_s = s_axis_tlast;

  assign hdr_sync_s   = s_axis_tdata[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_len_s    = s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
  assign sync_match_s = (hdr_sync_s == SYNC_WORD);
  assign len_ok_s     = (hdr_len_s != 16'd0) && (hdr_len_s <= MAX_LEN_C);

  // Output register can take a new word unless it is holding a stalled one
  assign out_free_s   = !m_valid_r || m_axis_tready;
  assign accept_s     = s_axis_tvalid && s_ready_s;

  // Idle timer only advances while waiting on input, never on output stall
  assign tout_fire_s  = (state_r != HUNT) && !accept_s && out_free_s &&
                        (idle_r == TOUT_LAST_C);

  // Input ready: always open while hunting, otherwise follows output space
  always_comb begin
    s_ready_s = 1'b1;
    if (state_r == HUNT) begin
      s_ready_s = 1'b1;
    end else begin
      s_ready_s = out_free_s;
    end
  end

  // Per-cycle decode of output pushes and statistics events
  always_comb begin
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_user_s = 1'b0;
    ok_inc_s    = 1'b0;
    sync_inc_s  = 1'b0;
    len_inc_s   = 1'b0;
    csum_inc_s  = 1'b0;
    tout_inc_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (accept_s && !sync_match_s) begin
          sync_inc_s = 1'b1;
        end else if (accept_s && !len_ok_s) begin
          len_inc_s = 1'b1;
        end else begin
          sync_inc_s = 1'b0;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          push_s = hold_vld_r;
        end else if (tout_fire_s) begin
          push_s      = hold_vld_r;
          push_last_s = 1'b1;
          push_user_s = 1'b1;
          tout_inc_s  = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      CHECK: begin
        if (accept_s) begin
          push_s      = hold_vld_r;
          push_last_s = 1'b1;
          if (s_axis_tdata == csum_r) begin
            push_user_s = 1'b0;
            ok_inc_s    = 1'b1;
          end else begin
            push_user_s = 1'b1;
            csum_inc_s  = 1'b1;
          end
        end else if (tout_fire_s) begin
          push_s      = hold_vld_r;
          push_last_s = 1'b1;
          push_user_s = 1'b1;
          tout_inc_s  = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Frame FSM: header hunt, payload staging through hold, checksum, timeout
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state_r    <= HUNT;
      len_r      <= 16'd0;
      wcnt_r     <= 16'd0;
      csum_r     <= 32'd0;
      hold_r     <= 32'd0;
      hold_vld_r <= 1'b0;
      idle_r     <= '0;
    end else begin
      case (state_r)
        HUNT: begin
          idle_r     <= '0;
          hold_vld_r <= 1'b0;
          if (accept_s && sync_match_s && len_ok_s) begin
            len_r   <= hdr_len_s;
            wcnt_r  <= 16'd0;
            csum_r  <= 32'd0;
            state_r <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (accept_s) begin
            csum_r     <= csum_update(csum_r, s_axis_tdata);
            wcnt_r     <= wcnt_r + 16'd1;
            hold_r     <= s_axis_tdata;
            hold_vld_r <= 1'b1;
            idle_r     <= '0;
            if ((wcnt_r + 16'd1) == len_r) begin
              state_r <= CHECK;
            end
          end else if (tout_fire_s) begin
            hold_vld_r <= 1'b0;
            idle_r     <= '0;
            state_r    <= HUNT;
          end else if (out_free_s) begin
            idle_r <= idle_r + IDLE_W'(1'b1);
          end
        end
        CHECK: begin
          if (accept_s || tout_fire_s) begin
            hold_vld_r <= 1'b0;
            idle_r     <= '0;
            state_r    <= HUNT;
          end else if (out_free_s) begin
            idle_r <= idle_r + IDLE_W'(1'b1);
          end
        end
        default: begin
          hold_vld_r <= 1'b0;
          idle_r     <= '0;
          state_r    <= HUNT;
        end
      endcase
    end
  end

  // AXIS output register: load on push, clear once taken, hold while stalled
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      m_valid_r <= 1'b0;
      m_data_r  <= 32'd0;
      m_last_r  <= 1'b0;
      m_user_r  <= 1'b0;
    end else if (push_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= hold_r;
      m_last_r  <= push_last_s;
      m_user_r  <= push_user_s;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_user_r  <= 1'b0;
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tdata  = m_data_r;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tlast  = m_last_r;
  assign m_axis_tuser  = m_user_r;
  assign busy          = (state_r != HUNT);

  ftdi_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc_en(ok_inc_s), .count(ok_cnt)
  );

  ftdi_sat_counter #(.CNT_W(CNT_W)) u_sync_err_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc_en(sync_inc_s), .count(sync_err_cnt)
  );

  ftdi_sat_counter #(.CNT_W(CNT_W)) u_len_err_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc_en(len_inc_s), .count(len_err_cnt)
  );

  ftdi_sat_counter #(.CNT_W(CNT_W)) u_csum_err_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc_en(csum_inc_s), .count(csum_err_cnt)
  );

  ftdi_sat_counter #(.CNT_W(CNT_W)) u_tout_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc_en(tout_inc_s), .count(tout_cnt)
  );

endmodule
